seq_detect_n: RTL and testbench



---
 rtl/seq_detect_pkg.sv | 27 ++
 rtl/seq_detect_n_tick_div.sv | 30 +++
 rtl/seq_detect_n.sv | 171 +++++++++++++++++
 tb/tb_seq_detect_n.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared types and constants for the seq_detect_n serial pattern detector.
//   seg_t       : 7-bit segment vector {a,b,c,d,e,f,g}, active-low
//   SEG_LUT     : hex digit 0..F encodings
//   SEG_RESET   : segments showing "0"
//   SEG_OFF     : all segments dark
//   PAT_W_MIN/MAX : legal pattern length range
package seq_detect_pkg;

  typedef logic [6:0] seg_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 15;

  localparam seg_t SEG_LUT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  localparam seg_t SEG_RESET = 7'h01;
  localparam seg_t SEG_OFF   = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] v);
    return SEG_LUT[v];
  endfunction

endpackage

// File: rtl/seq_detect_n_tick_div.sv
// tick_div
// Free-running divider producing a one-clk strobe every DIV cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset (counter -> 0)
//   tick : high for one clk while the counter sits at DIV-1
module tick_div #(
  parameter int DIV = 20000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seq_detect_n.sv
// seq_detect_n
// Serial detector for a runtime-loadable PAT_W-bit pattern (MSB first),
// sampled once per divided-clock tick, overlapping or non-overlapping.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   x               : serial data, used on ticks only
//   overlap         : 1 = overlapping matches (sampled on ticks)
//   pat_ld, pat_in  : load a new pattern (clears progress, keeps count)
//   y               : match flag for the last tick
//   match_cnt       : saturating match count
//   prog            : matched-prefix length
//   a..g            : active-low seven-segment display of prog
//   redled          : heartbeat, toggles every tick
// Build option: define SEQ_DETECT_SSEG_EN to drive the segments from prog;
// otherwise a..g are held at 1 (dark).
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               DIV     = 20000000,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [3:0]       prog,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g,
  output logic             redled
);

  localparam int KW = $clog2(PAT_W_MAX + 1);

  logic tick;

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;   // previous PAT_W-1 bits, newest in LSB
  logic [KW-1:0]    k_q, k_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redled_q, redled_d;

  // History including the bit arriving on this tick.
  logic [PAT_W-1:0] h;
  assign h = {hist_q, x};

  // cand[j]: last j bits equal the first j pattern bits. The prefix can grow
  // by at most one per tick, so j is capped at k+1; this also keeps zeroes
  // left behind by a history clear from ever forming a false prefix.
  logic [PAT_W:0]   cand;
  // bcand[j]: pattern has a border of length j (used for overlap restart).
  logic [PAT_W-1:0] bcand;

  assign cand[0]  = 1'b1;
  assign bcand[0] = 1'b0;

  for (genvar gi = 1; gi <= PAT_W; gi++) begin : g_cand
    assign cand[gi] = (h[gi-1:0] == pat_q[PAT_W-1 -: gi]) &&
                      ({1'b0, k_q} >= (KW+1)'(gi - 1));
  end

  for (genvar gi = 1; gi < PAT_W; gi++) begin : g_border
    assign bcand[gi] = (pat_q[gi-1:0] == pat_q[PAT_W-1 -: gi]);
  end

  logic [KW-1:0] new_k;
  logic [KW-1:0] border;
  logic          match;

  always_comb begin
    new_k = '0;
    for (int j = 0; j <= PAT_W; j++) begin
      if (cand[j]) new_k = KW'(j);
    end
    border = '0;
    for (int j = 0; j < PAT_W; j++) begin
      if (bcand[j]) border = KW'(j);
    end
    match = (new_k == KW'(PAT_W));
  end

  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    k_d      = k_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    redled_d = redled_q;
    if (pat_ld) begin
      // Load beats a coincident tick: its x is dropped, heartbeat still runs.
      pat_d  = pat_in;
      hist_d = '0;
      k_d    = '0;
      y_d    = 1'b0;
      if (tick) redled_d = ~redled_q;
    end else if (tick) begin
      redled_d = ~redled_q;
      hist_d   = h[PAT_W-2:0];
      y_d      = match;
      if (match) begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (overlap) begin
          k_d = border;
        end else begin
          k_d    = '0;
          hist_d = '0;
        end
      end else begin
        k_d = new_k;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q    <= PATTERN;
      hist_q   <= '0;
      k_q      <= '0;
      y_q      <= 1'b0;
      cnt_q    <= '0;
      redled_q <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      hist_q   <= hist_d;
      k_q      <= k_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      redled_q <= redled_d;
    end
  end

  assign y         = y_q;
  assign match_cnt = cnt_q;
  assign prog      = 4'(k_q);
  assign redled    = redled_q;

`ifdef SEQ_DETECT_SSEG_EN
  seg_t seg_q;

  // Registered from the next prog value so the display tracks prog exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_RESET;
    end else begin
      seg_q <= hex_to_seg(4'(k_d));
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
`else
  assign {a, b, c, d, e, f, g} = SEG_OFF;
`endif

endmodule

// File: tb/tb_seq_detect_n.sv
module tb_seq_detect_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic       overlap;
  logic       pat_ld;
  logic [3:0] pat_in;
  logic       y;
  logic [1:0] match_cnt;
  logic [3:0] prog;
  logic       a, b, c, d, e, f, g;
  logic       redled;

  int   errors = 0;
  int   checks = 0;
  logic red_exp;

  always #5 clk = ~clk;

  seq_detect_n #(
    .PAT_W   (4),
    .PATTERN (4'b1101),
    .DIV     (4),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .overlap   (overlap),
    .pat_ld    (pat_ld),
    .pat_in    (pat_in),
    .y         (y),
    .match_cnt (match_cnt),
    .prog      (prog),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .redled    (redled)
  );

  function automatic logic [6:0] seg_exp(input int v);
`ifdef SEQ_DETECT_SSEG_EN
    if (v == 0) return 7'b0000001;
    else        return 7'b0000110;   // digit 3
`else
    return (v == 0) ? 7'b1111111 : 7'b1111111;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One tick period: x held for DIV cycles, results sampled after the tick edge.
  task automatic do_tick(input logic xv, input int ep, input logic ey, input string tag);
    x = xv;
    repeat (4) @(negedge clk);
    red_exp = ~red_exp;
    chk({tag, ".prog"},   32'(prog),   32'(ep));
    chk({tag, ".y"},      32'(y),      32'(ey));
    chk({tag, ".redled"}, 32'(redled), 32'(red_exp));
  endtask

  // Called at a negedge: one rst cycle, reset values checked, then released.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, ".rst_y"},   32'(y),         32'(0));
    chk({tag, ".rst_cnt"}, 32'(match_cnt), 32'(0));
    chk({tag, ".rst_prog"},32'(prog),      32'(0));
    chk({tag, ".rst_red"}, 32'(redled),    32'(0));
    chk({tag, ".rst_seg"}, 32'({a, b, c, d, e, f, g}), 32'(seg_exp(0)));
    rst     = 1'b0;
    red_exp = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    x       = 1'b0;
    overlap = 1'b1;
    pat_ld  = 1'b0;
    pat_in  = 4'b0000;
    red_exp = 1'b0;
    @(negedge clk);

    // Overlapping 1101 on 1,1,0,1,1,0,1
    do_reset("t1");
    overlap = 1'b1;
    do_tick(1, 1, 0, "t1.1");
    do_tick(1, 2, 0, "t1.2");
    do_tick(0, 3, 0, "t1.3");
    do_tick(1, 1, 1, "t1.4");
    do_tick(1, 2, 0, "t1.5");
    do_tick(0, 3, 0, "t1.6");
    do_tick(1, 1, 1, "t1.7");
    chk("t1.cnt", 32'(match_cnt), 32'(2));

    // Non-overlapping, same stream
    do_reset("t2");
    overlap = 1'b0;
    do_tick(1, 1, 0, "t2.1");
    do_tick(1, 2, 0, "t2.2");
    do_tick(0, 3, 0, "t2.3");
    do_tick(1, 0, 1, "t2.4");
    do_tick(1, 1, 0, "t2.5");
    do_tick(0, 0, 0, "t2.6");
    do_tick(1, 1, 0, "t2.7");
    chk("t2.cnt", 32'(match_cnt), 32'(1));

    // Fallback 1,1,1,0,1 and display of digit 3
    do_reset("t3");
    overlap = 1'b1;
    do_tick(1, 1, 0, "t3.1");
    do_tick(1, 2, 0, "t3.2");
    do_tick(1, 2, 0, "t3.3");
    do_tick(0, 3, 0, "t3.4");
    chk("t3.seg3", 32'({a, b, c, d, e, f, g}), 32'(seg_exp(3)));
    do_tick(1, 1, 1, "t3.5");
    chk("t3.cnt", 32'(match_cnt), 32'(1));

    // Counter saturation: six non-overlapping matches with a 2-bit counter
    do_reset("t4");
    overlap = 1'b0;
    for (int m = 1; m <= 6; m++) begin
      do_tick(1, 1, 0, "t4.a");
      do_tick(1, 2, 0, "t4.b");
      do_tick(0, 3, 0, "t4.c");
      do_tick(1, 0, 1, "t4.d");
      chk("t4.cnt", 32'(match_cnt), 32'((m > 3) ? 3 : m));
    end

    // Pattern load coinciding with a tick whose x=1
    do_reset("t5");
    overlap = 1'b1;
    do_tick(1, 1, 0, "t5.1");
    do_tick(1, 2, 0, "t5.2");
    x = 1'b1;
    repeat (3) @(negedge clk);
    pat_ld = 1'b1;
    pat_in = 4'b0110;
    @(negedge clk);
    pat_ld  = 1'b0;
    red_exp = ~red_exp;
    chk("t5.ld_prog",   32'(prog),   32'(0));
    chk("t5.ld_y",      32'(y),      32'(0));
    chk("t5.ld_redled", 32'(redled), 32'(red_exp));
    do_tick(0, 1, 0, "t5.3");
    do_tick(1, 2, 0, "t5.4");
    do_tick(1, 3, 0, "t5.5");
    do_tick(0, 1, 1, "t5.6");
    chk("t5.cnt", 32'(match_cnt), 32'(1));

    // Mid-stream reset with prog=3, redled=1; rst overrides a pending load
    do_tick(1, 2, 0, "t6.1");
    do_tick(1, 3, 0, "t6.2");
    chk("t6.pre_red", 32'(redled), 32'(1));
    chk("t6.pre_seg", 32'({a, b, c, d, e, f, g}), 32'(seg_exp(3)));
    x = 1'b1;
    @(negedge clk);
    pat_ld = 1'b1;
    pat_in = 4'b0110;
    do_reset("t6");
    pat_ld = 1'b0;
    x = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6.no_early_tick", 32'(redled), 32'(0));
    @(negedge clk);
    red_exp = 1'b1;
    chk("t6.first_tick_red",  32'(redled), 32'(1));
    chk("t6.first_tick_prog", 32'(prog),   32'(1));
    do_tick(1, 2, 0, "t6.3");
    do_tick(0, 3, 0, "t6.4");
    do_tick(1, 1, 1, "t6.5");
    chk("t6.cnt", 32'(match_cnt), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
